znmi_track: RTL
===============

Name: znmi_track

Overview:
- Bus-side counterpart of the NMI generator: watches the Z80 respond to NMI_N.
- Follows the acknowledge sequence: dummy M1, two stack pushes, fetch at #0066.
- Captures the pushed return address and SP, then decodes the RETN (ED 45) opcode fetch that ends the handler.
- Gives slavespi/zports an exact entry/exit status and a one-fclk retn_stb, usable as an automatic clear-NMI pulse.

Parameters:
TMO_W, 8, width of the zpos-tick timeout counter used in acknowledge states (timeout = 2^TMO_W-1 ticks with no bus-cycle end)

Ports:
fclk       in   1   system clock
rst_n      in   1   synchronous active-low reset
zpos       in   1   Z80 clock rising-edge strobe (one fclk)
zneg       in   1   Z80 clock falling-edge strobe (one fclk)
gen_nmi    in   1   NMI generator output, 1 = NMI_N driven low
m1_n       in   1   Z80 M1
mreq_n     in   1   Z80 MREQ
rd_n       in   1   Z80 RD
wr_n       in   1   Z80 WR
rfsh_n     in   1   Z80 RFSH
a          in   16  Z80 address bus
d          in   8   Z80 data bus (as seen by FPGA)
err_clr    in   1   clears err (pulse from zports)
nmi_ack    out  1   one-fclk pulse: #0066 fetch of acknowledge completed
retn_stb   out  1   one-fclk pulse: RETN fetched inside handler
ret_addr   out  16  return PC pushed during acknowledge
sp_addr    out  16  address of the second (low-byte) push = SP inside handler
active     out  1   1 from entering INSIDE until retn_stb
err        out  1   sticky: acknowledge sequence aborted or timed out

Behaviour:
- Reset (rst_n=0 at fclk edge): state IDLE; every output 0; timeout counter 0.
- Bus sampling:
  - m1_n, rd_n registered on zpos; mreq_n, wr_n, rfsh_n registered on zneg.
- Cycle start: registered mreq_n 1->0. At start, latch type and a:
  - M1 = m1_n low.
  - WR = wr_n low, checked on the following zneg.
  - RD otherwise.
  - Refresh (rfsh_n low) is never a cycle.
- d is latched on every zpos while mreq_n=0 and (rd_n=0 or wr_n=0). The value held at cycle end is the cycle data.
- Cycle end: registered mreq_n 0->1 with a non-refresh cycle open. Produces one internal "end" fclk with type, address and data.
- States and transitions, evaluated on "end" unless stated:
  - IDLE: gen_nmi=1 -> ARMED (level-checked every fclk).
  - ARMED: M1 end -> PUSH_HI (this is the dummy acknowledge M1). Non-M1 ends ignored; they belong to the instruction still finishing.
  - PUSH_HI: WR end -> ret_addr[15:8]<=data, go to PUSH_LO. RD/M1 end -> abort.
  - PUSH_LO: WR end -> ret_addr[7:0]<=data, sp_addr<=cycle address, go to FETCH. Other end -> abort.
  - FETCH: M1 end with address #0066 -> INSIDE, nmi_ack=1 that fclk, active=1. Other end -> abort.
  - INSIDE: M1 end with data #ED -> ED_SEEN. Everything else stays in INSIDE.
  - ED_SEEN, on M1 end:
    - data #45 -> retn_stb=1 that fclk, active=0, go to IDLE.
    - data #ED -> stay in ED_SEEN.
    - anything else (including #4D RETI) -> INSIDE.
  - ED_SEEN, on non-M1 end (operand/data reads): stay in ED_SEEN. ED xx instructions never start with a data cycle before the second opcode.
- Abort: state -> IDLE, err<=1, ret_addr/sp_addr keep their partial values.
- Timeout (ARMED, PUSH_HI, PUSH_LO, FETCH only):
  - Counter increments on zpos and clears on every cycle end and on state change.
  - Reaching all-ones -> abort.
- gen_nmi rising while INSIDE/ED_SEEN is ignored; there is no nesting.
- err_clr clears err. An abort in the same fclk wins, so err stays 1.
- retn_stb and nmi_ack are never asserted in the same fclk. Each lasts exactly one fclk.
- Reset mid-sequence returns to IDLE immediately and drops active with no retn_stb.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ARMED, PUSH_HI, PUSH_LO, FETCH, INSIDE, ED_SEEN);
  - opcode constants OP_ED=#ED, OP_RETN=#45;
  - NMI_VEC=#0066.
- One natural sub-module: zbus_cycle. It holds the strobe registering, cycle start/end detection, type/address/data latching, and refresh exclusion. It outputs end, is_m1, is_wr, cyc_addr, cyc_data.
- The FSM, timeout and outputs stay in znmi_track.

Test Plan:
- Normal entry: gen_nmi high 4 zpos; M1 @#1234; WR @#7FFF d=#12; WR @#7FFE d=#34; M1 @#0066 -> nmi_ack one fclk, active=1, ret_addr=#1234, sp_addr=#7FFE, err=0.
- Exit: from INSIDE, M1 fetches d=#ED, #ED, #45 -> retn_stb one fclk on third end, active=0, state IDLE. Sequence ED,4D (RETI) -> no retn_stb, active stays 1.
- Refresh exclusion: refresh cycles with a=#0066 and d=#45 between every M1 in all flows -> no state effect; results identical to the first two scenarios.
- Abort: after dummy M1, an RD cycle instead of WR -> err=1, state IDLE, no nmi_ack. err_clr pulse -> err=0. err_clr coinciding with a second abort -> err=1.
- Timeout: TMO_W=4; gen_nmi pulse, then no mreq activity for 15 zpos -> err=1, state IDLE.
- Reset mid-handler: rst_n low one fclk while INSIDE -> active=0, all outputs 0, no retn_stb. A following ED 45 fetch produces nothing.

Source files
------------

// File: rtl/znmi_track_pkg.sv
// znmi_track_pkg: shared definitions for the NMI acknowledge/RETN tracker.
//   state_t : tracker FSM encoding
//   OP_ED   : first opcode byte of the ED-prefixed group
//   OP_RETN : second opcode byte of RETN (ED 45)
//   NMI_VEC : Z80 NMI entry address
package znmi_track_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_PUSH_HI = 3'd2,
        ST_PUSH_LO = 3'd3,
        ST_FETCH   = 3'd4,
        ST_INSIDE  = 3'd5,
        ST_ED_SEEN = 3'd6
    } state_t;

    localparam logic [7:0]  OP_ED   = 8'hED;
    localparam logic [7:0]  OP_RETN = 8'h45;
    localparam logic [15:0] NMI_VEC = 16'h0066;

endpackage

// File: rtl/zbus_cycle.sv
// zbus_cycle: turns raw Z80 bus strobes into one "cycle end" pulse per
// memory cycle, carrying the cycle type, address and data.
//   fclk, rst_n     : system clock, synchronous active-low reset
//   zpos, zneg      : Z80 clock rising/falling edge strobes
//   m1_n..rfsh_n    : raw Z80 control lines
//   a, d            : raw Z80 address / data bus
//   cyc_end         : one-fclk pulse when a non-refresh cycle finishes
//   is_m1, is_wr    : type of the finished cycle (neither set = RD)
//   cyc_addr        : address latched at cycle start
//   cyc_data        : last data value latched during the cycle
module zbus_cycle (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        zpos,
    input  logic        zneg,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    output logic        cyc_end,
    output logic        is_m1,
    output logic        is_wr,
    output logic [15:0] cyc_addr,
    output logic [7:0]  cyc_data
);

    logic m1_r, rd_r, mreq_r, wr_r, rfsh_r;
    logic open_q;   // a non-refresh cycle is in progress
    logic wr_chk;   // WR is decided on the zneg after the start

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            m1_r     <= 1'b1;
            rd_r     <= 1'b1;
            mreq_r   <= 1'b1;
            wr_r     <= 1'b1;
            rfsh_r   <= 1'b1;
            open_q   <= 1'b0;
            wr_chk   <= 1'b0;
            cyc_end  <= 1'b0;
            is_m1    <= 1'b0;
            is_wr    <= 1'b0;
            cyc_addr <= '0;
            cyc_data <= '0;
        end else begin
            cyc_end <= 1'b0;
            if (zpos) begin
                m1_r <= m1_n;
                rd_r <= rd_n;
                // Sampled strobes make this the T3 rising edge, where the
                // Z80 itself samples read data; refresh never loads d.
                if (!mreq_r && rfsh_r && (!rd_r || !wr_r))
                    cyc_data <= d;
            end
            if (zneg) begin
                mreq_r <= mreq_n;
                wr_r   <= wr_n;
                rfsh_r <= rfsh_n;
                if (mreq_r && !mreq_n) begin
                    // Refresh starts leave the previous cycle info intact.
                    open_q <= rfsh_n;
                    if (rfsh_n) begin
                        is_m1    <= ~m1_r;
                        is_wr    <= 1'b0;
                        wr_chk   <= m1_r;
                        cyc_addr <= a;
                    end
                end else begin
                    if (wr_chk) begin
                        is_wr  <= ~wr_n;
                        wr_chk <= 1'b0;
                    end
                    if (!mreq_r && mreq_n && open_q) begin
                        cyc_end <= 1'b1;
                        open_q  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/znmi_track.sv
// znmi_track: follows the Z80 NMI acknowledge (dummy M1, two pushes,
// fetch at NMI_VEC), captures return address and SP, and flags the RETN
// that leaves the handler.
//   fclk, rst_n         : system clock, synchronous active-low reset
//   zpos, zneg          : Z80 clock edge strobes
//   gen_nmi             : NMI generator output (1 = NMI_N low)
//   m1_n..rfsh_n, a, d  : Z80 bus as seen by the FPGA
//   err_clr             : clears err
//   nmi_ack, retn_stb   : one-fclk entry / exit pulses
//   ret_addr, sp_addr   : pushed return PC and handler SP
//   active              : handler running
//   err                 : sticky acknowledge abort / timeout flag
module znmi_track
    import znmi_track_pkg::*;
#(
    parameter int TMO_W = 8
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        zpos,
    input  logic        zneg,
    input  logic        gen_nmi,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    input  logic        err_clr,
    output logic        nmi_ack,
    output logic        retn_stb,
    output logic [15:0] ret_addr,
    output logic [15:0] sp_addr,
    output logic        active,
    output logic        err
);

    logic        cyc_end, is_m1, is_wr;
    logic [15:0] cyc_addr;
    logic [7:0]  cyc_data;

    zbus_cycle u_bus (
        .fclk     (fclk),
        .rst_n    (rst_n),
        .zpos     (zpos),
        .zneg     (zneg),
        .m1_n     (m1_n),
        .mreq_n   (mreq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .rfsh_n   (rfsh_n),
        .a        (a),
        .d        (d),
        .cyc_end  (cyc_end),
        .is_m1    (is_m1),
        .is_wr    (is_wr),
        .cyc_addr (cyc_addr),
        .cyc_data (cyc_data)
    );

    state_t           state, state_nx;
    logic [TMO_W-1:0] tmo;
    logic             in_ack, tmo_hit;
    logic             abort, ack_nx, retn_nx, ld_hi, ld_lo;

    assign in_ack  = state inside {ST_ARMED, ST_PUSH_HI, ST_PUSH_LO, ST_FETCH};
    assign tmo_hit = in_ack && (&tmo);

    // State register
    always_ff @(posedge fclk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        abort    = 1'b0;
        ack_nx   = 1'b0;
        retn_nx  = 1'b0;
        ld_hi    = 1'b0;
        ld_lo    = 1'b0;
        case (state)
            ST_IDLE:    if (gen_nmi) state_nx = ST_ARMED;
            // Non-M1 ends here belong to the instruction still finishing.
            ST_ARMED:   if (cyc_end && is_m1) state_nx = ST_PUSH_HI;
            ST_PUSH_HI: if (cyc_end) begin
                            if (is_wr) begin
                                ld_hi    = 1'b1;
                                state_nx = ST_PUSH_LO;
                            end else abort = 1'b1;
                        end
            ST_PUSH_LO: if (cyc_end) begin
                            if (is_wr) begin
                                ld_lo    = 1'b1;
                                state_nx = ST_FETCH;
                            end else abort = 1'b1;
                        end
            ST_FETCH:   if (cyc_end) begin
                            if (is_m1 && cyc_addr == NMI_VEC) begin
                                ack_nx   = 1'b1;
                                state_nx = ST_INSIDE;
                            end else abort = 1'b1;
                        end
            ST_INSIDE:  if (cyc_end && is_m1 && cyc_data == OP_ED)
                            state_nx = ST_ED_SEEN;
            // Operand/data reads keep the ED prefix pending.
            ST_ED_SEEN: if (cyc_end && is_m1) begin
                            if (cyc_data == OP_RETN) begin
                                retn_nx  = 1'b1;
                                state_nx = ST_IDLE;
                            end else if (cyc_data != OP_ED)
                                state_nx = ST_INSIDE;
                        end
            default:    state_nx = ST_IDLE;
        endcase
        // A cycle end in the same fclk is handled above and clears the timer.
        if (tmo_hit && !cyc_end) abort = 1'b1;
        if (abort) state_nx = ST_IDLE;
    end

    // Outputs
    always_comb begin
        active = (state == ST_INSIDE) || (state == ST_ED_SEEN);
    end

    // Registered pulses, captured addresses, error flag and timeout counter
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            nmi_ack  <= 1'b0;
            retn_stb <= 1'b0;
            ret_addr <= '0;
            sp_addr  <= '0;
            err      <= 1'b0;
            tmo      <= '0;
        end else begin
            nmi_ack  <= ack_nx;
            retn_stb <= retn_nx;
            if (ld_hi) ret_addr[15:8] <= cyc_data;
            if (ld_lo) begin
                ret_addr[7:0] <= cyc_data;
                sp_addr       <= cyc_addr;
            end
            if (abort)        err <= 1'b1;
            else if (err_clr) err <= 1'b0;
            if (!in_ack || cyc_end || state_nx != state) tmo <= '0;
            else if (zpos)                              tmo <= tmo + 1'b1;
        end
    end

endmodule
